input_conditioner: RTL and testbench



---
 rtl/calc_pkg.sv | 17 +
 rtl/input_conditioner_if.sv | 22 ++
 rtl/debounce_bit.sv | 52 +++++
 rtl/input_conditioner.sv | 61 ++++++
 tb/tb_input_conditioner.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator datapath and its front-end.
package calc_pkg;

    localparam int unsigned NUM_SW  = 8;
    localparam int unsigned NUM_BTN = 3;
    localparam int unsigned NUM_IN  = NUM_SW + NUM_BTN;

    localparam int unsigned BTN_ADD = 0;
    localparam int unsigned BTN_SUB = 1;
    localparam int unsigned BTN_CLR = 2;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    typedef logic [NUM_SW-1:0]  sw_t;
    typedef logic [NUM_BTN-1:0] btn_t;

endpackage

// File: rtl/input_conditioner_if.sv
// Board-pin side and conditioned side of the input front-end.
interface input_conditioner_if;
    import calc_pkg::*;

    sw_t  sw_raw;
    btn_t btn_raw;
    sw_t  sw;
    btn_t btn_level;
    btn_t btn_press;
    logic sw_update;

    modport master (
        output sw_raw, btn_raw,
        input  sw, btn_level, btn_press, sw_update
    );

    modport slave (
        input  sw_raw, btn_raw,
        output sw, btn_level, btn_press, sw_update
    );

endinterface

// File: rtl/debounce_bit.sv
// Two-flop synchroniser followed by a hold-counter debouncer for one raw input.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_q,
    output logic o_q_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_q;
    logic             w_q_next;

    // Any cycle where the synchronised input agrees with q restarts the count.
    always_comb begin
        w_q_next   = r_q;
        w_cnt_next = '0;
        if (r_sync2 != r_q) begin
            if (r_cnt >= CNT_MAX) begin
                w_q_next = r_sync2;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_q     <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_cnt   <= w_cnt_next;
            r_q     <= w_q_next;
        end
    end

    assign o_q      = r_q;
    assign o_q_next = w_q_next;

endmodule

// File: rtl/input_conditioner.sv
// Synchronises and debounces switches and buttons; emits press and switch-update pulses.
module input_conditioner
    import calc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input logic                clk,
    input logic                rst_n,
    input_conditioner_if.slave bus
);

    logic [NUM_IN-1:0] w_raw;
    logic [NUM_IN-1:0] w_q;
    logic [NUM_IN-1:0] w_q_next;

    sw_t  w_sw_q;
    sw_t  w_sw_next;
    btn_t w_btn_q;
    btn_t w_btn_next;

    btn_t r_btn_press;
    logic r_sw_update;

    assign w_raw = {bus.btn_raw, bus.sw_raw};

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_raw    (w_raw[gi]),
            .o_q      (w_q[gi]),
            .o_q_next (w_q_next[gi])
        );
    end

    assign w_sw_q     = w_q[NUM_SW-1:0];
    assign w_sw_next  = w_q_next[NUM_SW-1:0];
    assign w_btn_q    = w_q[NUM_IN-1:NUM_SW];
    assign w_btn_next = w_q_next[NUM_IN-1:NUM_SW];

    // Pulses are computed from the next q so they land on the same edge as acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_press <= '0;
            r_sw_update <= 1'b0;
        end else begin
            r_btn_press <= w_btn_next & ~w_btn_q;
            r_sw_update <= |(w_sw_next ^ w_sw_q);
        end
    end

    assign bus.sw        = w_sw_q;
    assign bus.btn_level = w_btn_q;
    assign bus.btn_press = r_btn_press;
    assign bus.sw_update = r_sw_update;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-cycle debounce window.
module tb_input_conditioner;
    import calc_pkg::*;

    localparam int unsigned DB = 4;

    logic clk = 1'b0;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    always #15 clk = ~clk;

    input_conditioner_if u_if ();

    input_conditioner #(
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advances n cycles, accumulating press pulse bits and switch-update pulses.
    task automatic count_pulses(input int n, inout int np, inout int nu);
        repeat (n) begin
            step(1);
            np += int'(u_if.btn_press[0]) + int'(u_if.btn_press[1]) + int'(u_if.btn_press[2]);
            nu += int'(u_if.sw_update);
        end
    endtask

    int np;
    int nu;

    initial begin
        // Reset with all inputs active
        rst_n          = 1'b0;
        u_if.sw_raw    = 8'hFF;
        u_if.btn_raw   = 3'b111;
        step(3);
        check_eq("rst_sw", 32'(u_if.sw), 32'h0);
        check_eq("rst_level", 32'(u_if.btn_level), 32'h0);
        check_eq("rst_press", 32'(u_if.btn_press), 32'h0);
        check_eq("rst_update", 32'(u_if.sw_update), 32'h0);
        u_if.sw_raw  = 8'h00;
        u_if.btn_raw = 3'b000;
        step(1);
        rst_n = 1'b1;
        step(10);
        check_eq("idle_sw", 32'(u_if.sw), 32'h0);
        check_eq("idle_level", 32'(u_if.btn_level), 32'h0);

        // Clean press: pulse at edge 6
        u_if.btn_raw = 3'b001;
        step(5);
        check_eq("press_e5", 32'(u_if.btn_press), 32'h0);
        step(1);
        check_eq("press_e6", 32'(u_if.btn_press), 32'h1);
        check_eq("level_e6", 32'(u_if.btn_level), 32'h1);
        step(1);
        check_eq("press_e7", 32'(u_if.btn_press), 32'h0);
        np = 0; nu = 0;
        count_pulses(10, np, nu);
        check_eq("held_no_repeat", 32'(np), 32'h0);
        u_if.btn_raw = 3'b000;
        np = 0;
        count_pulses(10, np, nu);
        check_eq("release_no_pulse", 32'(np), 32'h0);
        check_eq("release_level", 32'(u_if.btn_level), 32'h0);

        // Glitch of 3 cycles is rejected
        np = 0;
        u_if.btn_raw = 3'b010;
        count_pulses(3, np, nu);
        u_if.btn_raw = 3'b000;
        count_pulses(12, np, nu);
        check_eq("glitch_pulses", 32'(np), 32'h0);
        check_eq("glitch_level", 32'(u_if.btn_level), 32'h0);

        // Bounce train then steady high: exactly one pulse
        np = 0;
        for (int i = 0; i < 4; i++) begin
            u_if.btn_raw = (i % 2 == 0) ? 3'b010 : 3'b000;
            count_pulses(1, np, nu);
        end
        u_if.btn_raw = 3'b010;
        count_pulses(5, np, nu);
        check_eq("bounce_early", 32'(np), 32'h0);
        count_pulses(1, np, nu);
        check_eq("bounce_press", 32'(u_if.btn_press), 32'h2);
        count_pulses(6, np, nu);
        check_eq("bounce_total", 32'(np), 32'h1);
        check_eq("bounce_level", 32'(u_if.btn_level), 32'h2);
        u_if.btn_raw = 3'b000;
        step(8);

        // Switch update
        u_if.sw_raw = 8'h11;
        step(5);
        check_eq("swupd_e5", 32'(u_if.sw_update), 32'h0);
        step(1);
        check_eq("swupd_e6", 32'(u_if.sw_update), 32'h1);
        check_eq("sw_e6", 32'(u_if.sw), 32'h11);
        step(1);
        check_eq("swupd_e7", 32'(u_if.sw_update), 32'h0);
        u_if.sw_raw = 8'h91;
        step(1);
        u_if.sw_raw = 8'h11;
        nu = 0;
        count_pulses(10, np, nu);
        check_eq("flicker_update", 32'(nu), 32'h0);
        check_eq("flicker_sw", 32'(u_if.sw), 32'h11);

        // Simultaneous button and switch events
        u_if.btn_raw = 3'b101;
        u_if.sw_raw  = 8'h22;
        step(5);
        check_eq("simul_press_e5", 32'(u_if.btn_press), 32'h0);
        step(1);
        check_eq("simul_press", 32'(u_if.btn_press), 32'h5);
        check_eq("simul_update", 32'(u_if.sw_update), 32'h1);
        check_eq("simul_sw", 32'(u_if.sw), 32'h22);
        step(1);
        check_eq("simul_press_e7", 32'(u_if.btn_press), 32'h0);
        check_eq("simul_update_e7", 32'(u_if.sw_update), 32'h0);
        u_if.btn_raw = 3'b000;
        step(8);

        // Reset mid-count, button held through reset
        u_if.btn_raw = 3'b001;
        step(4);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_level", 32'(u_if.btn_level), 32'h0);
        check_eq("midrst_sw", 32'(u_if.sw), 32'h0);
        step(2);
        rst_n = 1'b1;
        step(5);
        check_eq("postrst_press_e5", 32'(u_if.btn_press), 32'h0);
        check_eq("postrst_update_e5", 32'(u_if.sw_update), 32'h0);
        step(1);
        check_eq("postrst_press_e6", 32'(u_if.btn_press), 32'h1);
        check_eq("postrst_update_e6", 32'(u_if.sw_update), 32'h1);
        check_eq("postrst_sw", 32'(u_if.sw), 32'h22);
        step(1);
        check_eq("postrst_press_e7", 32'(u_if.btn_press), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
